uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 208 ++++++++++++++++++++
 tb/tb_uart_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: UART 8N1 frame receiver that writes a length-prefixed, checksummed payload into memory
module uart_loader #(
    parameter int CLKS_PER_BIT = 234,
    parameter int MAX_LEN      = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_write,
    output logic        mem_req,
    input  logic        mem_done,
    output logic        load_active,
    output logic        load_done,
    output logic        load_error
);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, SUM} ld_state_t;

    logic        rx_meta, rx_sync, rx_prev;
    rx_state_t   rs, rs_nxt;
    logic [15:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        byte_valid, frame_err;

    ld_state_t   ls, ls_nxt;
    logic [7:0]  len_hi, len_hi_nxt;
    logic [15:0] len, len_nxt;
    logic [16:0] cnt, cnt_nxt;
    logic [7:0]  sum, sum_nxt;
    logic [7:0]  skid, skid_nxt;
    logic        skid_full, skid_full_nxt;
    logic [7:0]  mem_data_nxt;
    logic        mem_req_nxt, load_done_nxt, load_error_nxt;
    logic        take, abort;
    logic [7:0]  in_byte;

    // two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // receiver state and bit-timing registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs      <= R_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rs      <= rs_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // receiver: mid-bit sampling, false-start rejection, stop-bit check and re-arm on rx high
    always_comb begin
        rs_nxt      = rs;
        bit_cnt_nxt = bit_cnt + 16'd1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_valid  = 1'b0;
        frame_err   = 1'b0;
        case (rs)
            R_IDLE: begin
                bit_cnt_nxt = '0;
                rs_nxt      = (rx_prev && !rx_sync) ? R_START : R_IDLE;
            end
            R_START: if (bit_cnt == HALF_END) begin
                bit_cnt_nxt = '0;
                bit_idx_nxt = '0;
                rs_nxt      = rx_sync ? R_IDLE : R_DATA;
            end
            R_DATA: if (bit_cnt == BIT_END) begin
                bit_cnt_nxt = '0;
                shreg_nxt   = {rx_sync, shreg[7:1]};
                bit_idx_nxt = bit_idx + 3'd1;
                rs_nxt      = (bit_idx == 3'd7) ? R_STOP : R_DATA;
            end
            R_STOP: if (bit_cnt == BIT_END) begin
                byte_valid = rx_sync;
                frame_err  = !rx_sync;
                rs_nxt     = rx_sync ? R_IDLE : R_WAIT;
            end
            R_WAIT: rs_nxt = rx_sync ? R_IDLE : R_WAIT;
            default: rs_nxt = R_IDLE;
        endcase
    end

    // loader state, counters, skid buffer and memory-side registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ls         <= IDLE;
            len_hi     <= '0;
            len        <= '0;
            cnt        <= '0;
            sum        <= '0;
            skid       <= '0;
            skid_full  <= 1'b0;
            mem_data   <= '0;
            mem_req    <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            ls         <= ls_nxt;
            len_hi     <= len_hi_nxt;
            len        <= len_nxt;
            cnt        <= cnt_nxt;
            sum        <= sum_nxt;
            skid       <= skid_nxt;
            skid_full  <= skid_full_nxt;
            mem_data   <= mem_data_nxt;
            mem_req    <= mem_req_nxt;
            load_done  <= load_done_nxt;
            load_error <= load_error_nxt;
        end
    end

    // loader: skid-buffered byte intake, frame parsing, write handshake and abort handling
    always_comb begin
        ls_nxt         = ls;
        len_hi_nxt     = len_hi;
        len_nxt        = len;
        cnt_nxt        = cnt;
        sum_nxt        = sum;
        skid_nxt       = skid;
        skid_full_nxt  = skid_full;
        mem_data_nxt   = mem_data;
        mem_req_nxt    = mem_req;
        load_done_nxt  = load_done;
        load_error_nxt = load_error;
        abort          = 1'b0;
        take           = 1'b0;
        in_byte        = skid_full ? skid : shreg;
        if (ls == WRITE) begin
            abort         = byte_valid && skid_full;
            skid_full_nxt = skid_full || byte_valid;
            skid_nxt      = (byte_valid && !skid_full) ? shreg : skid;
        end else begin
            take          = skid_full || byte_valid;
            skid_full_nxt = skid_full && byte_valid;
            skid_nxt      = (skid_full && byte_valid) ? shreg : skid;
        end
        case (ls)
            IDLE: if (take && in_byte == 8'hA5) begin
                ls_nxt         = LEN_HI;
                load_done_nxt  = 1'b0;
                load_error_nxt = 1'b0;
                cnt_nxt        = '0;
                sum_nxt        = '0;
            end
            LEN_HI: if (take) begin
                len_hi_nxt = in_byte;
                ls_nxt     = LEN_LO;
            end
            LEN_LO: if (take) begin
                len_nxt = {len_hi, in_byte};
                abort   = {1'b0, len_hi, in_byte} > MAX_LEN_W;
                ls_nxt  = ({len_hi, in_byte} == 16'd0) ? SUM : DATA;
            end
            DATA: if (take) begin
                mem_data_nxt = in_byte;
                sum_nxt      = sum + in_byte;
                mem_req_nxt  = 1'b1;
                ls_nxt       = WRITE;
            end
            WRITE: if (mem_req && mem_done) begin
                mem_req_nxt = 1'b0;
                cnt_nxt     = cnt + 17'd1;
                ls_nxt      = (cnt + 17'd1 == {1'b0, len}) ? SUM : DATA;
            end
            SUM: if (take) begin
                abort         = in_byte != sum;
                load_done_nxt = in_byte == sum;
                ls_nxt        = IDLE;
            end
            default: ls_nxt = IDLE;
        endcase
        if (frame_err && ls != IDLE) abort = 1'b1;
        if (abort) begin
            ls_nxt         = IDLE;
            load_error_nxt = 1'b1;
            load_done_nxt  = 1'b0;
            mem_req_nxt    = 1'b0;
            skid_full_nxt  = 1'b0;
        end
    end

    assign mem_addr    = cnt[15:0];
    assign mem_write   = mem_req;
    assign load_active = ls != IDLE;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized frame stimulus with a scoreboard of expected memory writes and frame outcomes
module tb_uart_loader;
    localparam int CPB = 8;
    localparam int MAXL = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clock, reset, rx, mem_done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write, mem_req, load_active, load_done, load_error;

    wr_t        exp_wr[$];
    logic [1:0] exp_st[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         done_delay = 1;
    bit         noise = 0;

    uart_loader #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAXL)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write), .mem_req(mem_req),
        .mem_done(mem_done), .load_active(load_active), .load_done(load_done), .load_error(load_error)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: parse the frame from the byte stream and list the writes and outcome it implies
    task automatic model(input bq_t f);
        int i = 0;
        int n;
        int s = 0;
        wr_t w;
        while (f[i] != 8'hA5) i++;
        n = int'(f[i+1]) * 256 + int'(f[i+2]);
        if (n > MAXL) begin
            exp_st.push_back(2'b01);
            return;
        end
        for (int k = 0; k < n; k++) begin
            w.a = 16'(k);
            w.d = f[i+3+k];
            exp_wr.push_back(w);
            s = (s + int'(f[i+3+k])) % 256;
        end
        exp_st.push_back((int'(f[i+3+n]) == s) ? 2'b10 : 2'b01);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clock);
        end
        rx = 1;
    endtask

    task automatic send_frame(input bq_t f);
        foreach (f[i]) begin
            send_byte(f[i], 1'b1);
            repeat ($urandom_range(0, 10)) @(negedge clock);
        end
    endtask

    task automatic glitch();
        rx = 0;
        repeat (2) @(negedge clock);
        rx = 1;
        repeat (20) @(negedge clock);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && load_active; i++) @(negedge clock);
        check("frame_end_active", int'(load_active), 0);
        repeat (5) @(negedge clock);
    endtask

    // memory responder: completes a request done_delay cycles after it appears, noise while idle
    initial begin
        int wc = 0;
        mem_done = 0;
        forever begin
            @(negedge clock);
            if (mem_req) begin
                mem_done = wc >= done_delay;
                if (wc < done_delay) wc++;
            end else begin
                wc = 0;
                mem_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // monitor: pops expected writes on each request and expected outcomes when a frame ends
    initial begin
        logic prev_req = 0;
        logic prev_act = 0;
        logic stable = 1;
        logic [15:0] cap_a = 0;
        logic [7:0] cap_d = 0;
        wr_t w;
        logic [1:0] st;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_req = 0;
                prev_act = 0;
            end else begin
                if (mem_req && !prev_req) begin
                    if (exp_wr.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_write: addr=%0h data=%0h with no write expected", mem_addr, mem_data);
                    end else begin
                        w = exp_wr.pop_front();
                        check("write_addr", int'(mem_addr), int'(w.a));
                        check("write_data", int'(mem_data), int'(w.d));
                    end
                    check("write_strobe", int'(mem_write), 1);
                    cap_a = mem_addr;
                    cap_d = mem_data;
                    stable = 1;
                end else if (mem_req && (mem_addr != cap_a || mem_data != cap_d)) begin
                    stable = 0;
                end
                if (!mem_req && prev_req) check("write_stable", int'(stable), 1);
                if (!load_active && prev_act) begin
                    if (exp_st.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_frame_end: done=%0b error=%0b", load_done, load_error);
                    end else begin
                        st = exp_st.pop_front();
                        check("load_done", int'(load_done), int'(st[1]));
                        check("load_error", int'(load_error), int'(st[0]));
                    end
                end
                prev_req = mem_req;
                prev_act = load_active;
            end
        end
    end

    initial begin
        bq_t q;
        wr_t w;
        int n;
        int s;
        reset = 1;
        rx = 1;
        repeat (3) @(negedge clock);
        check("rst_active", int'(load_active), 0);
        check("rst_req", int'(mem_req), 0);
        check("rst_done", int'(load_done), 0);
        check("rst_error", int'(load_error), 0);
        check("rst_addr", int'(mem_addr), 0);
        reset = 0;
        repeat (5) @(negedge clock);

        q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        model(q); send_frame(q); wait_idle();
        q = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h31};
        model(q); send_frame(q); wait_idle();
        q = '{8'hA5, 8'h00, 8'h05};
        model(q); send_frame(q); wait_idle();
        q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        model(q); send_frame(q); wait_idle();

        q = '{8'hA5, 8'h00, 8'h01, 8'h7E, 8'h7E};
        model(q);
        send_byte(8'hA5, 1'b1);
        glitch();
        q = '{8'h00, 8'h01, 8'h7E, 8'h7E};
        send_frame(q); wait_idle();

        exp_st.push_back(2'b01);
        glitch();
        send_byte(8'hA5, 1'b1);
        repeat (3) @(negedge clock);
        send_byte(8'h3C, 1'b0);
        repeat (20) @(negedge clock);
        wait_idle();

        done_delay = 300;
        w.a = 16'h0; w.d = 8'h11;
        exp_wr.push_back(w);
        exp_st.push_back(2'b01);
        q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_frame(q); wait_idle();

        done_delay = 100000;
        w.a = 16'h0; w.d = 8'h5A;
        exp_wr.push_back(w);
        q = '{8'hA5, 8'h00, 8'h02, 8'h5A};
        send_frame(q);
        for (int i = 0; i < 100 && !mem_req; i++) @(negedge clock);
        check("req_before_reset", int'(mem_req), 1);
        check("active_before_reset", int'(load_active), 1);
        reset = 1;
        #1;
        check("async_rst_req", int'(mem_req), 0);
        check("async_rst_write", int'(mem_write), 0);
        check("async_rst_active", int'(load_active), 0);
        check("async_rst_done", int'(load_done), 0);
        check("async_rst_error", int'(load_error), 0);
        check("async_rst_data", int'(mem_data), 0);
        repeat (3) @(negedge clock);
        reset = 0;
        done_delay = 2;
        repeat (5) @(negedge clock);
        q = '{8'hA5, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h28};
        model(q); send_frame(q); wait_idle();

        noise = 1;
        for (int f = 0; f < 20; f++) begin
            done_delay = $urandom_range(1, 4);
            q = {};
            if ($urandom_range(0, 2) == 0) q.push_back(8'(($urandom_range(0, 254) + 8'hA6) % 256));
            n = $urandom_range(0, MAXL + 1);
            q.push_back(8'hA5);
            q.push_back(8'h00);
            q.push_back(8'(n));
            if (n <= MAXL) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    q.push_back(8'($urandom_range(0, 255)));
                    s = (s + int'(q[q.size()-1])) % 256;
                end
                q.push_back(($urandom_range(0, 3) == 0) ? 8'(s ^ $urandom_range(1, 255)) : 8'(s));
            end
            model(q); send_frame(q); wait_idle();
        end

        check("writes_left", exp_wr.size(), 0);
        check("outcomes_left", exp_st.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
